// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU codes, result select,
// immediate formats and the ID/EX control bundle.
package rv_pkg;

  localparam int XLEN_W = 32;
  localparam int REG_AW = 5;
  localparam int ALU_W  = 4;
  localparam int RES_W  = 2;
  localparam int F3_W   = 3;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic [ALU_W-1:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [RES_W-1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } res_src_e;

  typedef enum logic [2:0] {
    IMM_I, IMM_S, IMM_B, IMM_J, IMM_U
  } imm_sel_e;

  typedef struct packed {
    logic     reg_write;
    logic     mem_write;
    logic     jump;
    logic     branch;
    logic     alu_src_a;
    logic     alu_src_b;
    res_src_e result_src;
    alu_op_e  alu_ctrl;
    logic     illegal;
  } ctrl_t;

  // funct3 -> ALU op for OP / OP-IMM. Only OP may turn ADD into SUB;
  // bit 30 on an OP-IMM add is part of the immediate.
  function automatic alu_op_e alu_from_funct(input logic [2:0] f3,
                                             input logic f7b5,
                                             input logic is_op);
    alu_op_e op;
    case (f3)
      3'b000:  op = (is_op && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 architectural register file: x0 reads zero, write-first bypass,
// asynchronous clear.
module regfile
  import rv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [XLEN-1:0]   wd,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic [XLEN-1:0]   rd1,
  output logic [XLEN-1:0]   rd2
);

  logic [NREG-1:0][XLEN-1:0] mem;
  logic                      wr_ok;

  assign wr_ok = we && (wa != '0);

  // Storage update; x0 is never written so its slot stays zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mem <= '0;
    else if (wr_ok) mem[wa] <= wd;
  end

  // Combinational reads with same-cycle writeback forwarding.
  always_comb begin
    rd1 = mem[ra1];
    rd2 = mem[ra2];
    if (wr_ok && wa == ra1) rd1 = wd;
    if (wr_ok && wa == ra2) rd2 = wd;
    if (ra1 == '0) rd1 = '0;
    if (ra2 == '0) rd2 = '0;
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: control decode, immediate generation, register
// read and the ID/EX pipeline register.
module decode_stage
  import rv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instrD,
  input  logic [XLEN-1:0]   PCD,
  input  logic              flushE,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RdW,
  input  logic [XLEN-1:0]   ResultW,
  output logic [REG_AW-1:0] Rs1D,
  output logic [REG_AW-1:0] Rs2D,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [XLEN-1:0]   PCE,
  output logic [REG_AW-1:0] Rs1E,
  output logic [REG_AW-1:0] Rs2E,
  output logic [REG_AW-1:0] RdE,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              JumpE,
  output logic              BranchE,
  output logic              ALUSrcAE,
  output logic              ALUSrcBE,
  output logic [RES_W-1:0]  ResultSrcE,
  output logic [ALU_W-1:0]  ALUControlE,
  output logic [F3_W-1:0]   funct3E,
  output logic              IllegalE
);

  logic [6:0]        opcode;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic [XLEN-1:0]   rd1, rd2;
  ctrl_t             ctrl, ctrl_q;
  imm_sel_e          imm_sel;
  logic signed [31:0] imm32;
  logic [XLEN-1:0]   imm_ext;

  assign opcode = instrD[6:0];
  assign f3     = instrD[14:12];
  assign f7     = instrD[31:25];
  assign Rs1D   = instrD[19:15];
  assign Rs2D   = instrD[24:20];

  regfile #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clk (clk),
    .rst (rst),
    .we  (RegWriteW),
    .wa  (RdW),
    .wd  (ResultW),
    .ra1 (Rs1D),
    .ra2 (Rs2D),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  // Main control decode; anything unrecognised leaves a bubble plus the illegal flag.
  always_comb begin
    ctrl    = '0;
    imm_sel = IMM_I;
    case (opcode)
      OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.alu_ctrl  = ALU_PASSB;
        imm_sel        = IMM_U;
      end
      OP_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 1'b1;
        imm_sel        = IMM_U;
      end
      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.alu_src_b  = 1'b1;
        ctrl.result_src = RES_PC4;
        imm_sel         = IMM_J;
      end
      OP_JALR: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.alu_src_b  = 1'b1;
        ctrl.result_src = RES_PC4;
      end
      OP_BRANCH: begin
        ctrl.branch   = 1'b1;
        ctrl.alu_ctrl = ALU_SUB;
        imm_sel       = IMM_B;
      end
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src_b  = 1'b1;
        ctrl.result_src = RES_MEM;
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        imm_sel        = IMM_S;
      end
      OP_IMM: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.alu_ctrl  = alu_from_funct(f3, instrD[30], 1'b0);
      end
      OP_OP: begin
        // Only funct7=0, or 0x20 on ADD/SRL, is a base-ISA OP.
        if (f7 == 7'b0000000 ||
            (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
          ctrl.reg_write = 1'b1;
          ctrl.alu_ctrl  = alu_from_funct(f3, f7[5], 1'b1);
        end else begin
          ctrl.illegal = 1'b1;
        end
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

  // Immediate assembly; every format sign-extends from instrD[31].
  always_comb begin
    case (imm_sel)
      IMM_S:   imm32 = {{20{instrD[31]}}, instrD[31:25], instrD[11:7]};
      IMM_B:   imm32 = {{20{instrD[31]}}, instrD[7], instrD[30:25], instrD[11:8], 1'b0};
      IMM_J:   imm32 = {{12{instrD[31]}}, instrD[19:12], instrD[20], instrD[30:21], 1'b0};
      IMM_U:   imm32 = {instrD[31:12], 12'b0};
      default: imm32 = {{20{instrD[31]}}, instrD[31:20]};
    endcase
  end

  assign imm_ext = XLEN'(imm32);

  // ID/EX register: loads every cycle, cleared by reset or flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q  <= '0;
      RD1E    <= '0;
      RD2E    <= '0;
      ImmExtE <= '0;
      PCE     <= '0;
      Rs1E    <= '0;
      Rs2E    <= '0;
      RdE     <= '0;
      funct3E <= '0;
    end else if (flushE) begin
      ctrl_q  <= '0;
      RD1E    <= '0;
      RD2E    <= '0;
      ImmExtE <= '0;
      PCE     <= '0;
      Rs1E    <= '0;
      Rs2E    <= '0;
      RdE     <= '0;
      funct3E <= '0;
    end else begin
      ctrl_q  <= ctrl;
      RD1E    <= rd1;
      RD2E    <= rd2;
      ImmExtE <= imm_ext;
      PCE     <= PCD;
      Rs1E    <= Rs1D;
      Rs2E    <= Rs2D;
      RdE     <= instrD[11:7];
      funct3E <= f3;
    end
  end

  assign RegWriteE   = ctrl_q.reg_write;
  assign MemWriteE   = ctrl_q.mem_write;
  assign JumpE       = ctrl_q.jump;
  assign BranchE     = ctrl_q.branch;
  assign ALUSrcAE    = ctrl_q.alu_src_a;
  assign ALUSrcBE    = ctrl_q.alu_src_b;
  assign ResultSrcE  = ctrl_q.result_src;
  assign ALUControlE = ctrl_q.alu_ctrl;
  assign IllegalE    = ctrl_q.illegal;

endmodule

// File: doc/decode_stage.md
# decode_stage

Second stage of the five-stage RV32I pipeline: consumes `instrD`/`PCD` from the fetch stage, decodes control, reads the register file, sign-extends immediates and registers everything into the ID/EX pipeline register for the execute stage. It also owns the 32x32 register file, written by the writeback stage, with write-first bypass.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `NREG`, 32, architectural register count (x0 hardwired zero)

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `instrD` input 32: instruction from the IF/ID register.
- `PCD` input 32: PC of `instrD`.
- `flushE` input 1: from the hazard unit; loads a bubble into ID/EX.
- `RegWriteW` input 1: writeback write enable.
- `RdW` input 5: writeback destination register.
- `ResultW` input 32: writeback data.
- `Rs1D`, `Rs2D` output 5: combinational source fields, for the hazard unit.
- `RD1E`, `RD2E` output 32: registered operands.
- `ImmExtE` output 32: registered immediate.
- `PCE` output 32: registered PC.
- `Rs1E`, `Rs2E`, `RdE` output 5: registered register indices.
- `RegWriteE`, `MemWriteE`, `JumpE`, `BranchE`, `ALUSrcAE`, `ALUSrcBE` output 1: registered control bits.
- `ResultSrcE` output 2: result select. 00 = ALU, 01 = memory, 10 = PC+4.
- `ALUControlE` output 4: ALU operation.
- `funct3E` output 3: passed through for branch compare and load/store width.
- `IllegalE` output 1: undecodable instruction flag.

## Operation
- Register file: 32 x 32 bits. Write on rising `clk` when `RegWriteW` is high and `RdW` != 0. Reads are combinational. x0 always reads 0.
- Write-first bypass: if `RegWriteW` is high, `RdW` != 0 and `RdW` equals the read index, the read returns `ResultW`.
- Immediate formats, all sign-extended from `instrD[31]`:
  - I type: `[31:20]`.
  - S type: `{[31:25],[11:7]}`.
  - B type: `{[31],[7],[30:25],[11:8],0}`.
  - J type: `{[31],[19:12],[20],[30:21],0}`.
  - U type: `{[31:12],12'b0}`.
- Opcodes decoded: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
- ALU operation codes:
  - ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB=10.
  - SUB is selected for OP with funct7[5]=1; SRA for funct7[5]=1 on a shift.
  - Loads, stores, JALR and AUIPC use ADD. LUI uses PASSB. Branches use SUB.
- `ALUSrcAE` selects the PC as operand A; it is set only for AUIPC. `ALUSrcBE` selects the immediate; it is set for everything except OP and BRANCH.
- `Rs1D`/`Rs2D`/`RdE` are taken from the fixed fields regardless of format.
- Illegal instruction (unknown opcode, or bad funct7 on OP): all control bits are zero (bubble) and `IllegalE`=1. Data fields are still registered.
- `instrD` = 0 (fetch reset value) decodes as illegal. `instrD` = 0x00000013 (NOP) decodes as legal with `RegWriteE`=1 and `RdE`=0.

## Timing
- Latency: 1 cycle from `instrD`/`PCD` to all `*E` outputs. `Rs1D`/`Rs2D` are combinational with 0 cycles of latency.
- `rst` low: all ID/EX outputs and all registers go to 0 asynchronously, and stay there while reset is held. The first capture happens on the first rising edge after release.
- `flushE` high at an edge: every ID/EX field loads 0, including `IllegalE`. The register file write in the same cycle still occurs.
- No stall input: ID/EX loads every cycle. The hazard unit stalls IF/ID and flushes E instead.
- A register-file write and a read of the same register in the same cycle: the reader sees the new value through the bypass. The stored value updates at the edge.
- Reset mid-operation discards the in-flight instruction. No partial state survives.

## Structure
- Shared package `rv_pkg` holds:
  - opcode constants;
  - ALU operation code constants;
  - ResultSrc encodings;
  - the ID/EX field widths.
- Sub-module `regfile`: the 32x32 array, the x0 rule, bypass and asynchronous reset clear.
- Control decode, immediate generation and the ID/EX register live in `decode_stage`.

## Test plan
- Reset, then load register x5=0x0000000A via writeback. Next cycle `instrD`=0x00528313 (addi x6,x5,5) -> after 1 edge: `RD1E`=0xA, `ImmExtE`=5, `RdE`=6, `ALUSrcBE`=1, `ALUControlE`=ADD, `RegWriteE`=1.
- `instrD`=0xFE000EE3 (beq x0,x0,-4) -> `ImmExtE`=0xFFFFFFFC, `BranchE`=1, `ALUControlE`=SUB, `RegWriteE`=0.
- Writeback of x7=0x1234 in the same cycle as `instrD`=0x00038413 (addi x8,x7,0) -> `RD1E`=0x1234 (bypass). Writeback with `RdW`=0 and data 0xFFFF -> a later read of x0 returns 0.
- `instrD`=0x123452B7 (lui x5,0x12345) -> `ImmExtE`=0x12345000, `ALUControlE`=PASSB. `instrD`=0xFFFFFFFF -> `IllegalE`=1 with all control bits zero.
- `flushE`=1 with a valid `instrD` -> all `*E` outputs are 0 next cycle. `rst` asserted mid-stream -> outputs are 0 immediately, before the next edge.
